// File: rtl/ddr5_cmd_issuer.sv
// rtl/ddr5_cmd_issuer.sv - pops mapped requests and expands them into timed DDR5 ACT/RD/WR/PRE commands
// Optional open-page policy is enabled by defining DDR5_OPEN_PAGE_EN.
module ddr5_cmd_issuer #(
    parameter int T_RCD   = 39,
    parameter int T_CL    = 40,
    parameter int T_CWL   = 38,
    parameter int T_BURST = 8,
    parameter int T_WR    = 72,
    parameter int T_RP    = 39,
    parameter int T_RAS   = 76
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_core,
    input  logic [1:0]  req_operation,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [15:0] req_row,
    input  logic [7:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd_code,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [7:0]  cmd_col,
    output logic        done,
    output logic [3:0]  done_core,
    output logic        busy
);

    if (T_RCD < 1 || T_RCD > 255 || T_CL < 1 || T_CL > 255 || T_CWL < 1 || T_CWL > 255 ||
        T_BURST < 1 || T_BURST > 255 || T_WR < 1 || T_WR > 255 || T_RP < 1 || T_RP > 255 ||
        T_RAS < 1 || T_RAS > 255) begin : g_bad_timing
        $error("ddr5_cmd_issuer: timing parameters must be within 1..255");
    end

    // Main timer is one bit wider because CL+BURST can exceed 255.
    localparam int TW = 9;

    typedef enum logic [2:0] {
        S_IDLE, S_ACT, S_WAIT_RCD, S_RDWR, S_WAIT_DATA, S_WAIT_PRE, S_PRE, S_WAIT_RP
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    // Timer loads are "cycles spent in the wait state"; zero means skip it.
    localparam logic [TW-1:0] LD_RCD = TW'(T_RCD - 1);
    localparam logic [TW-1:0] LD_RD  = TW'(T_CL + T_BURST - 1);
    localparam logic [TW-1:0] LD_WD  = TW'(T_CWL + T_BURST - 1);
    localparam logic [TW-1:0] LD_WR  = TW'(T_WR);
    localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);

    state_t        state, state_next;
    logic [TW-1:0] tmr, tmr_next;
    logic [7:0]    ras_cnt;
    logic [3:0]    cap_core;
    logic          cap_wr;
    logic [2:0]    cap_bg;
    logic [1:0]    cap_ba;
    logic [15:0]   cap_row;
    logic [7:0]    cap_col;

    logic          pop, req_is_wr;
    logic          f_wr;
    logic [2:0]    f_bg;
    logic [1:0]    f_ba;
    logic [15:0]   f_row;
    logic [7:0]    f_col;
    logic          cmd_valid_d, done_d, ready_d;
    logic [2:0]    cmd_code_d;

`ifdef DDR5_OPEN_PAGE_EN
    logic          open_valid, miss_q, hit;
    logic [2:0]    open_bg;
    logic [1:0]    open_ba;
    logic [15:0]   open_row;
    assign hit = (req_bg == open_bg) && (req_ba == open_ba) && (req_row == open_row);
`endif

    assign pop       = req_valid && req_ready;
    assign req_is_wr = (req_operation == 2'd1);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            tmr        <= '0;
            ras_cnt    <= '0;
            cap_core   <= '0;
            cap_wr     <= 1'b0;
            cap_bg     <= '0;
            cap_ba     <= '0;
            cap_row    <= '0;
            cap_col    <= '0;
            req_ready  <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= CMD_NOP;
            cmd_bg     <= '0;
            cmd_ba     <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            done       <= 1'b0;
            done_core  <= '0;
`ifdef DDR5_OPEN_PAGE_EN
            open_valid <= 1'b0;
            miss_q     <= 1'b0;
            open_bg    <= '0;
            open_ba    <= '0;
            open_row   <= '0;
`endif
        end else begin
            state <= state_next;
            tmr   <= tmr_next;
            if (state_next == S_ACT) begin
                ras_cnt <= 8'(T_RAS);
            end else if (ras_cnt != 8'd0) begin
                ras_cnt <= ras_cnt - 8'd1;
            end
            if (pop) begin
                cap_core <= req_core;
                cap_wr   <= req_is_wr;
                cap_bg   <= req_bg;
                cap_ba   <= req_ba;
                cap_row  <= req_row;
                cap_col  <= req_col;
            end
            // Outputs are registered from the next state so they align with it.
            req_ready <= ready_d;
            cmd_valid <= cmd_valid_d;
            cmd_code  <= cmd_code_d;
            if (cmd_valid_d) begin
                cmd_bg  <= f_bg;
                cmd_ba  <= f_ba;
                cmd_row <= f_row;
                cmd_col <= f_col;
            end
            done <= done_d;
            if (done_d) begin
                done_core <= cap_core;
            end
`ifdef DDR5_OPEN_PAGE_EN
            if (state == S_RDWR) begin
                open_valid <= 1'b1;
                open_bg    <= cap_bg;
                open_ba    <= cap_ba;
                open_row   <= cap_row;
            end
            if (pop) begin
                miss_q <= open_valid && !hit;
            end
`endif
        end
    end

    always_comb begin
        state_next = state;
        tmr_next   = (tmr != '0) ? tmr - TW'(1) : '0;
        case (state)
            S_IDLE: begin
                if (pop) begin
`ifdef DDR5_OPEN_PAGE_EN
                    if (open_valid && hit) begin
                        state_next = S_RDWR;
                    end else if (open_valid) begin
                        if (ras_cnt > 8'd1) begin
                            state_next = S_WAIT_PRE;
                            tmr_next   = '0;
                        end else begin
                            state_next = S_PRE;
                        end
                    end else begin
                        state_next = S_ACT;
                    end
`else
                    state_next = S_ACT;
`endif
                end
            end
            S_ACT: begin
                if (LD_RCD == '0) begin
                    state_next = S_RDWR;
                end else begin
                    state_next = S_WAIT_RCD;
                    tmr_next   = LD_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (tmr <= TW'(1)) state_next = S_RDWR;
            end
            S_RDWR: begin
                state_next = S_WAIT_DATA;
                tmr_next   = cap_wr ? LD_WD : LD_RD;
            end
            S_WAIT_DATA: begin
                if (tmr <= TW'(1)) begin
`ifdef DDR5_OPEN_PAGE_EN
                    if (cap_wr) begin
                        state_next = S_WAIT_PRE;
                        tmr_next   = LD_WR;
                    end else begin
                        state_next = S_IDLE;
                    end
`else
                    if (!cap_wr && ras_cnt <= 8'd1) begin
                        state_next = S_PRE;
                    end else begin
                        state_next = S_WAIT_PRE;
                        tmr_next   = cap_wr ? LD_WR : '0;
                    end
`endif
                end
            end
            S_WAIT_PRE: begin
`ifdef DDR5_OPEN_PAGE_EN
                // Shared by row-miss precharge wait and open-page write recovery.
                if (miss_q) begin
                    if (ras_cnt <= 8'd1) state_next = S_PRE;
                end else if (tmr <= TW'(1)) begin
                    state_next = S_IDLE;
                end
`else
                if (tmr <= TW'(1) && ras_cnt <= 8'd1) state_next = S_PRE;
`endif
            end
            S_PRE: begin
                if (LD_RP == '0) begin
`ifdef DDR5_OPEN_PAGE_EN
                    state_next = S_ACT;
`else
                    state_next = S_IDLE;
`endif
                end else begin
                    state_next = S_WAIT_RP;
                    tmr_next   = LD_RP;
                end
            end
            S_WAIT_RP: begin
                if (tmr <= TW'(1)) begin
`ifdef DDR5_OPEN_PAGE_EN
                    state_next = S_ACT;
`else
                    state_next = S_IDLE;
`endif
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        f_wr  = pop ? req_is_wr : cap_wr;
        f_bg  = pop ? req_bg    : cap_bg;
        f_ba  = pop ? req_ba    : cap_ba;
        f_row = pop ? req_row   : cap_row;
        f_col = pop ? req_col   : cap_col;
`ifdef DDR5_OPEN_PAGE_EN
        // A precharge always closes the recorded open row, not the new request's.
        if (state_next == S_PRE) begin
            f_bg  = open_bg;
            f_ba  = open_ba;
            f_row = open_row;
        end
`endif
        cmd_valid_d = 1'b0;
        cmd_code_d  = CMD_NOP;
        case (state_next)
            S_ACT: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_ACT;
            end
            S_RDWR: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = f_wr ? CMD_WR : CMD_RD;
            end
            S_PRE: begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = CMD_PRE;
            end
            default: ;
        endcase
        done_d  = (state == S_WAIT_DATA) && (tmr <= TW'(1));
        ready_d = (state_next == S_IDLE);
    end

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
// tb/tb_ddr5_cmd_issuer.sv - directed self-checking bench for ddr5_cmd_issuer
module tb_ddr5_cmd_issuer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_core = '0;
    logic [1:0]  req_operation = '0;
    logic [2:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [15:0] req_row = '0;
    logic [7:0]  req_col = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_code;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [7:0]  cmd_col;
    logic        done;
    logic [3:0]  done_core;
    logic        busy;

    always #5 clock = ~clock;

    ddr5_cmd_issuer dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_core(req_core),
        .req_operation(req_operation), .req_bg(req_bg), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .done(done), .done_core(done_core), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int overlaps = 0;
    logic prev_cv = 1'b0;

    int          n_ev, wait_cyc, done_at, done_core_seen, ready_at, busy_at1, quiet;
    logic [2:0]  ev_code [4];
    int          ev_cyc  [4];
    logic [2:0]  ev_bg   [4];
    logic [1:0]  ev_ba   [4];
    logic [15:0] ev_row  [4];
    logic [7:0]  ev_col  [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        if (cmd_valid && prev_cv) overlaps++;
        prev_cv = cmd_valid;
    endtask

    // Offers a request, then logs every command/done/ready relative to the pop cycle.
    task automatic run_req(input logic [3:0] core, input logic [1:0] op, input logic [2:0] bg,
                           input logic [1:0] ba, input logic [15:0] row, input logic [7:0] col,
                           input bit hold, input int stop_at);
        req_core = core; req_operation = op; req_bg = bg; req_ba = ba;
        req_row = row; req_col = col; req_valid = 1'b1;
        n_ev = 0; wait_cyc = 0; done_at = -1; done_core_seen = -1; ready_at = -1; busy_at1 = -1;
        while (!req_ready && wait_cyc < 400) begin
            tick();
            wait_cyc++;
        end
        check("pop_ready", req_ready, 1);
        if (!req_ready) return;
        for (int k = 1; k <= stop_at; k++) begin
            tick();
            if (k == 1) begin
                req_valid = hold;
                busy_at1 = busy;
            end
            if (cmd_valid) begin
                if (n_ev < 4) begin
                    ev_code[n_ev] = cmd_code; ev_cyc[n_ev] = k; ev_bg[n_ev] = cmd_bg;
                    ev_ba[n_ev] = cmd_ba; ev_row[n_ev] = cmd_row; ev_col[n_ev] = cmd_col;
                end
                n_ev++;
            end
            if (done && done_at < 0) begin
                done_at = k;
                done_core_seen = done_core;
            end
            if (req_ready) begin
                ready_at = k;
                break;
            end
        end
    endtask

    task automatic check_ev(input string tag, input int i, input logic [2:0] code, input int cyc);
        check({tag, "_code"}, ev_code[i], code);
        check({tag, "_cyc"}, ev_cyc[i], cyc);
    endtask

    initial begin
        tick();
        tick();
        check("rst_ready", req_ready, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_code", cmd_code, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();
        check("rst_ready_rise", req_ready, 1);

        // Reset mid-read: in-flight request is dropped silently.
        run_req(4'd3, 2'd0, 3'd2, 2'd1, 16'h0ABC, 8'h33, 1'b0, 50);
        check_ev("mid_act", 0, 3'd1, 1);
        check_ev("mid_rd", 1, 3'd2, 40);
        check("mid_nev", n_ev, 2);
        #1 reset = 1'b1;
        #1;
        check("mid_ready", req_ready, 0);
        check("mid_cmd_valid", cmd_valid, 0);
        check("mid_cmd_row", cmd_row, 0);
        check("mid_cmd_col", cmd_col, 0);
        check("mid_busy", busy, 0);
        tick();
        tick();
        reset = 1'b0;
        #1 check("mid_ready_held", req_ready, 0);
        tick();
        check("mid_ready_rise", req_ready, 1);
        quiet = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (done || cmd_valid) quiet++;
        end
        check("mid_no_late_cmd", quiet, 0);

`ifndef DDR5_OPEN_PAGE_EN
        // Closed-page read.
        run_req(4'd2, 2'd0, 3'd1, 2'd2, 16'h1234, 8'h10, 1'b0, 600);
        check("rd_busy", busy_at1, 1);
        check("rd_nev", n_ev, 3);
        check_ev("rd_act", 0, 3'd1, 1);
        check("rd_act_row", ev_row[0], 16'h1234);
        check("rd_act_bg", ev_bg[0], 1);
        check("rd_act_ba", ev_ba[0], 2);
        check_ev("rd_rd", 1, 3'd2, 40);
        check("rd_rd_col", ev_col[1], 8'h10);
        check_ev("rd_pre", 2, 3'd4, 88);
        check("rd_pre_bg", ev_bg[2], 1);
        check("rd_done_at", done_at, 88);
        check("rd_done_core", done_core_seen, 2);
        check("rd_ready_at", ready_at, 127);

        // Closed-page write: precharge gated by write recovery.
        run_req(4'd5, 2'd1, 3'd3, 2'd1, 16'hBEEF, 8'h7F, 1'b0, 600);
        check("wr_nev", n_ev, 3);
        check_ev("wr_act", 0, 3'd1, 1);
        check("wr_act_row", ev_row[0], 16'hBEEF);
        check_ev("wr_wr", 1, 3'd3, 40);
        check("wr_wr_col", ev_col[1], 8'h7F);
        check_ev("wr_pre", 2, 3'd4, 158);
        check("wr_done_at", done_at, 86);
        check("wr_done_core", done_core_seen, 5);
        check("wr_ready_at", ready_at, 197);

        // Back-to-back: reserved op then instruction fetch, both behave as reads.
        run_req(4'd7, 2'd3, 3'd0, 2'd3, 16'h0A0A, 8'h01, 1'b1, 600);
        check("b1_nev", n_ev, 3);
        check_ev("b1_rd", 1, 3'd2, 40);
        check("b1_ready_at", ready_at, 127);
        run_req(4'd9, 2'd2, 3'd4, 2'd0, 16'h5555, 8'h22, 1'b0, 600);
        check("b2_no_gap", wait_cyc, 0);
        check("b2_nev", n_ev, 3);
        check_ev("b2_act", 0, 3'd1, 1);
        check("b2_act_row", ev_row[0], 16'h5555);
        check_ev("b2_rd", 1, 3'd2, 40);
        check("b2_rd_col", ev_col[1], 8'h22);
        check_ev("b2_pre", 2, 3'd4, 88);
        check("b2_done_at", done_at, 88);
        check("b2_done_core", done_core_seen, 9);
        check("b2_ready_at", ready_at, 127);
`else
        // Open-page: first read opens the row, ready returns at data end.
        run_req(4'd2, 2'd0, 3'd1, 2'd2, 16'h1234, 8'h10, 1'b1, 600);
        check("op1_nev", n_ev, 2);
        check_ev("op1_act", 0, 3'd1, 1);
        check_ev("op1_rd", 1, 3'd2, 40);
        check("op1_done_at", done_at, 88);
        check("op1_ready_at", ready_at, 88);
        // Row hit: RD right after the pop, no ACT.
        run_req(4'd4, 2'd0, 3'd1, 2'd2, 16'h1234, 8'h20, 1'b1, 600);
        check("op2_no_gap", wait_cyc, 0);
        check("op2_nev", n_ev, 1);
        check_ev("op2_rd", 0, 3'd2, 1);
        check("op2_rd_col", ev_col[0], 8'h20);
        check("op2_done_at", done_at, 49);
        check("op2_done_core", done_core_seen, 4);
        check("op2_ready_at", ready_at, 49);
        // Row miss in the same bank: PRE, ACT after T_RP, RD after T_RCD.
        run_req(4'd6, 2'd0, 3'd1, 2'd2, 16'h2000, 8'h30, 1'b0, 600);
        check("op3_nev", n_ev, 3);
        check_ev("op3_pre", 0, 3'd4, 1);
        check("op3_pre_ba", ev_ba[0], 2);
        check_ev("op3_act", 1, 3'd1, 40);
        check("op3_act_row", ev_row[1], 16'h2000);
        check_ev("op3_rd", 2, 3'd2, 79);
        check("op3_done_at", done_at, 127);
        check("op3_ready_at", ready_at, 127);
`endif

        check("no_cmd_overlap", overlaps, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
